pulse_rate_meter: RTL and testbench



---
 rtl/pulse_rate_meter.sv | 142 ++++++++++++++
 tb/tb_pulse_rate_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_rate_meter.sv
// rtl/pulse_rate_meter.sv - counts synchronised event pulses per programmable window, with a loss-of-events watchdog
module pulse_rate_meter #(
  parameter int WIN_W   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clkS,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             saturated,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;
  localparam logic [15:0]      TMO     = 16'(TIMEOUT);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_reg_q, win_reg_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             saturated_q, saturated_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] acc_next;
  logic             sat_next;
  logic             last_cycle;

  always_comb begin
    state_d       = state_q;
    win_reg_d     = win_reg_q;
    timer_d       = timer_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    saturated_d   = saturated_q;
    idle_cnt_d    = '0;

    // acc_next/sat_next include this cycle's pulse, so the last window cycle is counted
    acc_next   = (pulse_in && (acc_q != ACC_MAX)) ? acc_q + CNT_W'(1) : acc_q;
    sat_next   = sat_q | (pulse_in && (acc_q == ACC_MAX));
    last_cycle = (timer_q == win_reg_q - WIN_W'(1));

    case (state_q)
      IDLE: begin
        if (en && (win_len != '0)) begin
          state_d   = COUNT;
          win_reg_d = win_len;
          timer_d   = '0;
          acc_d     = '0;
          sat_d     = 1'b0;
        end
      end
      COUNT: begin
        if (last_cycle) begin
          count_valid_d = 1'b1;
          count_out_d   = acc_next;
          saturated_d   = sat_next;
          timer_d       = '0;
          acc_d         = '0;
          sat_d         = 1'b0;
          if (en && (win_len != '0)) begin
            win_reg_d = win_len;
          end else begin
            state_d = IDLE;
          end
        end else if (!en) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + WIN_W'(1);
          acc_d   = acc_next;
          sat_d   = sat_next;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog run survives gapless window restarts; any exit from COUNT clears it
    if ((state_q == COUNT) && (state_d == COUNT)) begin
      if (pulse_in) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TMO) begin
        idle_cnt_d = idle_cnt_q;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end

    timeout_d = (state_d == COUNT) && (idle_cnt_d == TMO);
    busy_d    = (state_d == COUNT);
  end

  always_ff @(posedge clkS) begin
    if (rst) begin
      state_q       <= IDLE;
      win_reg_q     <= '0;
      timer_q       <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      idle_cnt_q    <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      saturated_q   <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_reg_q     <= win_reg_d;
      timer_q       <= timer_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      idle_cnt_q    <= idle_cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      saturated_q   <= saturated_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign saturated   = saturated_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// tb/tb_pulse_rate_meter.sv - scoreboard bench for pulse_rate_meter against a window-level reference model
module tb_pulse_rate_meter;

  localparam int WIN_W   = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIN_W-1:0] win_len;
  logic             pulse_in;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             saturated;
  logic             timeout;
  logic             busy;

  always #5 clk = ~clk;

  pulse_rate_meter #(
    .WIN_W  (WIN_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clkS       (clk),
    .rst        (rst),
    .en         (en),
    .win_len    (win_len),
    .pulse_in   (pulse_in),
    .count_out  (count_out),
    .count_valid(count_valid),
    .saturated  (saturated),
    .timeout    (timeout),
    .busy       (busy)
  );

  typedef struct {
    int count;
    bit sat;
  } rep_t;

  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_on   = 1'b0;

  // Reference model: a window is simply the list of pulse bits seen while measuring
  bit m_active   = 1'b0;
  int m_len      = 0;
  bit m_bits[$];
  int m_idle_run = 0;
  int m_cout     = 0;
  bit m_csat     = 1'b0;
  bit m_busy     = 1'b0;
  bit m_timeout  = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active   = 1'b0;
      m_bits.delete();
      m_idle_run = 0;
      m_cout     = 0;
      m_csat     = 1'b0;
      exp_q.delete();
    end else if (!m_active) begin
      if (en && win_len != 0) begin
        m_active   = 1'b1;
        m_len      = int'(win_len);
        m_bits.delete();
        m_idle_run = 0;
      end
    end else begin
      m_bits.push_back(pulse_in);
      m_idle_run = pulse_in ? 0 : m_idle_run + 1;
      if (m_bits.size() == m_len) begin
        int   sum;
        rep_t r;
        sum = 0;
        foreach (m_bits[i]) sum += int'(m_bits[i]);
        r.count = (sum > CMAX) ? CMAX : sum;
        r.sat   = (sum > CMAX);
        exp_q.push_back(r);
        m_cout = r.count;
        m_csat = r.sat;
        m_bits.delete();
        if (en && win_len != 0) m_len = int'(win_len);
        else m_active = 1'b0;
      end else if (!en) begin
        m_active = 1'b0;
        m_bits.delete();
      end
    end
    if (!m_active) m_idle_run = 0;
    m_busy    = m_active;
    m_timeout = m_active && (m_idle_run >= TIMEOUT);
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("busy", int'(busy), int'(m_busy));
      check("timeout", int'(timeout), int'(m_timeout));
      if (count_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_count_valid", 1, 0);
        end else begin
          rep_t r;
          r = exp_q.pop_front();
          check("count_out", int'(count_out), r.count);
          check("saturated", int'(saturated), int'(r.sat));
        end
      end else begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          check("missing_count_valid", 0, 1);
        end
        check("count_out_hold", int'(count_out), m_cout);
        check("saturated_hold", int'(saturated), int'(m_csat));
      end
    end
  end

  task automatic tick(input bit r, input bit e, input int wl, input bit p);
    rst      = r;
    en       = e;
    win_len  = WIN_W'(wl);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int density;
    int wl;
    bit e;

    rst = 1'b1; en = 1'b0; win_len = '0; pulse_in = 1'b0;
    // Reset and idle with toggling pulses
    tick(1, 0, 10, 1);
    mon_on = 1'b1;
    tick(1, 0, 10, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 10, i[0]);

    // Basic window: start cycle, then window cycles 0..9 with pulses on 0, 3, 9
    tick(0, 1, 10, 1);
    for (int c = 0; c < 10; c++) tick(0, (c != 9), 10, (c == 0 || c == 3 || c == 9));
    for (int i = 0; i < 3; i++) tick(0, 0, 10, 0);

    // Back-to-back windows, then win_len change mid-window
    tick(0, 1, 4, 1);
    for (int c = 0; c < 14; c++) tick(0, 1, 4, 1);
    for (int c = 0; c < 20; c++) tick(0, 1, 6, 1);
    tick(0, 0, 6, 0);
    tick(0, 0, 6, 0);

    // Saturation, then a window of five pulses
    tick(0, 1, 20, 0);
    for (int c = 0; c < 20; c++) tick(0, 1, 20, 1);
    for (int c = 0; c < 20; c++) tick(0, (c != 19), 20, (c < 5));
    tick(0, 0, 20, 0);

    // Abort at window cycle 5 keeps the old count_out
    tick(0, 1, 10, 0);
    for (int c = 0; c < 5; c++) tick(0, 1, 10, (c == 1 || c == 3));
    tick(0, 0, 10, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 10, 0);
    // Reset at window cycle 5 clears count_out
    tick(0, 1, 10, 0);
    for (int c = 0; c < 5; c++) tick(0, 1, 10, (c == 1 || c == 3));
    tick(1, 1, 10, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 10, 0);

    // Watchdog across two empty windows, then a single pulse
    tick(0, 1, 8, 0);
    for (int c = 0; c < 20; c++) tick(0, 1, 8, 0);
    tick(0, 1, 8, 1);
    for (int c = 0; c < 4; c++) tick(0, 1, 8, 0);
    tick(0, 0, 8, 0);
    tick(0, 0, 8, 0);

    // Randomised traffic
    density = 50;
    wl      = 5;
    e       = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 4))
          0: density = 0;
          1: density = 10;
          2: density = 50;
          3: density = 90;
          default: density = 100;
        endcase
      end
      if ($urandom_range(0, 39) == 0) e = ~e;
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 7))
          0: wl = 0;
          1: wl = 1;
          2: wl = 30;
          default: wl = int'($urandom_range(2, 12));
        endcase
      end
      tick(($urandom_range(0, 599) == 0), e, wl, ($urandom_range(0, 99) < density));
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
